// File: rtl/mmio_timer_if.sv
// Purpose: CPU data-memory side bus between the core and the MMIO timer.
// Latency: combinational signals only; the interface itself adds no stages.
// Backpressure: none, every access completes in the cycle it is presented.
interface mmio_timer_if;
    logic        cs;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        hit;

    modport master (
        output cs, rd, wr, addr, wdata,
        input  rdata, hit
    );

    modport slave (
        input  cs, rd, wr, addr, wdata,
        output rdata, hit
    );
endinterface

// File: rtl/mmio_timer.sv
// Purpose: memory-mapped 32-bit timer with prescaler, compare match, auto-reload/one-shot and level irq.
// Latency: writes take effect at the next rising edge; reads are combinational; irq lags MATCH by one cycle.
// Backpressure: none, zero wait states; accesses never stall the CPU.
module mmio_timer #(
    parameter logic [31:0] BASE     = 32'h0000_1000,
    parameter int          PRESCALE = 1
) (
    input  logic         clk,
    input  logic         rst,
    mmio_timer_if.slave  bus,
    output logic         irq
);

    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_COUNT  = 2'd1,
        REG_CMP    = 2'd2,
        REG_STATUS = 2'd3
    } reg_sel_t;

    logic        ctrl_en;
    logic        ctrl_auto;
    logic        ctrl_ie;
    logic [31:0] count;
    logic [31:0] cmp;
    logic        match;
    logic [15:0] presc_cnt;

    logic        hit_i;
    reg_sel_t    sel;
    logic        wr_any;
    logic        wr_ctrl;
    logic        wr_count;
    logic        wr_cmp;
    logic        wr_status;
    logic        tick;
    logic        cmp_eq;
    logic        match_evt;

    // Byte-lane bits are ignored: every access is a full word.
    logic        unused_addr_lsb;
    assign unused_addr_lsb = ^bus.addr[1:0];

    assign hit_i     = bus.cs && (bus.addr[31:4] == BASE[31:4]);
    assign bus.hit   = hit_i;
    assign sel       = reg_sel_t'(bus.addr[3:2]);
    assign wr_any    = hit_i && bus.wr;
    assign wr_ctrl   = wr_any && (sel == REG_CTRL);
    assign wr_count  = wr_any && (sel == REG_COUNT);
    assign wr_cmp    = wr_any && (sel == REG_CMP);
    assign wr_status = wr_any && (sel == REG_STATUS);

    assign tick      = ctrl_en && (presc_cnt == PRESC_LAST);
    assign cmp_eq    = (count == cmp);
    // A COUNT write in the same cycle suppresses both increment and match.
    assign match_evt = tick && !wr_count && cmp_eq;

    // Prescaler: advances only while enabled, restarts on any CTRL write.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_cnt <= '0;
        end else if (wr_ctrl) begin
            presc_cnt <= '0;
        end else if (ctrl_en) begin
            presc_cnt <= tick ? 16'd0 : presc_cnt + 16'd1;
        end
    end

    // CTRL bits: a software write beats a same-edge one-shot disable.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_en   <= 1'b0;
            ctrl_auto <= 1'b0;
            ctrl_ie   <= 1'b0;
        end else if (wr_ctrl) begin
            ctrl_en   <= bus.wdata[0];
            ctrl_auto <= bus.wdata[1];
            ctrl_ie   <= bus.wdata[2];
        end else if (match_evt && !ctrl_auto) begin
            ctrl_en   <= 1'b0;
        end
    end

    // COUNT: software write has priority, otherwise count or reload on tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (wr_count) begin
            count <= bus.wdata;
        end else if (tick) begin
            if (!cmp_eq) begin
                count <= count + 32'd1;
            end else if (ctrl_auto) begin
                count <= '0;
            end
        end
    end

    // CMP: the old value is still used for a tick in the write cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmp <= 32'hFFFF_FFFF;
        end else if (wr_cmp) begin
            cmp <= bus.wdata;
        end
    end

    // MATCH: a hardware set wins over a same-edge software clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            match <= 1'b0;
        end else if (match_evt) begin
            match <= 1'b1;
        end else if (wr_status && bus.wdata[0]) begin
            match <= 1'b0;
        end
    end

    // irq is a registered copy of the enabled match flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= match && ctrl_ie;
        end
    end

    // Read mux: zero unless this is a decoded read with no write.
    always_comb begin
        bus.rdata = '0;
        if (hit_i && bus.rd && !bus.wr) begin
            case (sel)
                REG_CTRL:   bus.rdata = {29'd0, ctrl_ie, ctrl_auto, ctrl_en};
                REG_COUNT:  bus.rdata = count;
                REG_CMP:    bus.rdata = cmp;
                REG_STATUS: bus.rdata = {31'd0, match};
                default:    bus.rdata = '0;
            endcase
        end
    end

endmodule

// File: doc/mmio_timer.md
MMIO_TIMER -- requirements
Module: mmio_timer

Interface
REQ-001 Parameter BASE, default 32'h0000_1000: word-aligned base address; the block decodes BASE..BASE+15.
REQ-002 Parameter PRESCALE, default 1: clk cycles per count tick; legal range 1..65536.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 cs  input  1  data-memory chip select from the CPU.
REQ-006 rd  input  1  read strobe, qualified by cs.
REQ-007 wr  input  1  write strobe, qualified by cs.
REQ-008 addr  input  32  byte address from the CPU ALU result.
REQ-009 wdata  input  32  write data from the CPU rt operand.
REQ-010 rdata  output  32  read data, combinational.
REQ-011 hit  output  1  high when cs=1 and addr[31:4]==BASE[31:4]; the top level uses it to steer its read mux between DMEM and this block.
REQ-012 irq  output  1  interrupt request, level, registered.

Function
REQ-013 Register map by addr[3:2]:
- 0 CTRL: bit0 EN, bit1 AUTO, bit2 IE; bits 31:3 read 0.
- 1 COUNT: 32-bit.
- 2 CMP: 32-bit.
- 3 STATUS: bit0 MATCH; bits 31:1 read 0.
REQ-014 addr[1:0] shall be ignored; all accesses are full-word.
REQ-015 Write condition: hit=1 and wr=1; the register is updated at that rising edge; rd is ignored during a write.
REQ-016 Read data: rdata = selected register when hit=1, rd=1 and wr=0; otherwise rdata=0; zero wait states.
REQ-017 Prescaler: a 16-bit counter runs only while EN=1.
- Generates a one-cycle tick when it equals PRESCALE-1, then wraps to 0.
- PRESCALE=1: tick every cycle EN=1.
REQ-018 Tick when COUNT != CMP: COUNT <= COUNT+1, modulo 2^32 (32'hFFFF_FFFF wraps to 0).
REQ-019 Tick when COUNT == CMP:
- MATCH <= 1.
- If AUTO=1: COUNT <= 0.
- If AUTO=0: COUNT holds and EN <= 0 (one-shot).
REQ-020 irq = MATCH & IE, registered, so it asserts one cycle after MATCH sets or IE is written to 1.
REQ-021 CTRL write: the prescaler counter clears to 0 in the same edge.
REQ-022 COUNT write: COUNT takes wdata; a tick in that cycle has no effect on COUNT, and no match is evaluated in that cycle.
REQ-023 CMP write: the new value applies from the next tick; a tick in the write cycle compares against the old CMP.
REQ-024 STATUS write: wdata[0]=1 clears MATCH; wdata[0]=0 has no effect.
REQ-025 Same-cycle conflicts:
- A match setting MATCH in the same cycle as a STATUS clear leaves MATCH=1 (set wins).
- A one-shot match clearing EN in the same cycle as a CTRL write: the CTRL write wins.
REQ-026 Accesses with cs=0, or addresses outside BASE..BASE+15, shall not alter any state.

Reset
REQ-027 When rst=1 at an edge: CTRL=0, COUNT=0, CMP=32'hFFFF_FFFF, MATCH=0, prescaler=0, irq=0.
REQ-028 rst=1 overrides any same-cycle bus write or tick.
REQ-029 rst asserted mid-count aborts counting; after rst deasserts, counting stays stopped until software sets EN.
REQ-030 rdata and hit are combinational and depend on rst only through register contents.

Verification
REQ-031 PRESCALE=1, CMP=3, CTRL=3 (EN, AUTO) -> COUNT sequence 0,1,2,3,0,1; MATCH=1 from the edge of the 3->0 tick; irq stays 0 because IE=0.
REQ-032 PRESCALE=4, CMP=2, CTRL=5 (EN, IE), AUTO=0 -> COUNT increments every 4 cycles to 2; the next tick sets MATCH and clears EN; COUNT holds at 2; irq=1 one cycle later; STATUS write 1 -> MATCH=0, then irq=0 the following cycle.
REQ-033 COUNT written to 32'hFFFF_FFFF, CMP=5, EN=1 -> the next tick gives COUNT=0, with no MATCH.
REQ-034 Match tick coincident with a STATUS clear -> MATCH remains 1; a COUNT write of 32'h10 in the same cycle as a tick -> COUNT reads 32'h10.
REQ-035 Read and decode with BASE=32'h1000: addr 32'h1008, rd=1 -> rdata=CMP and hit=1; addr 32'h1010 -> hit=0 and rdata=0; cs=0 with wr=1 at 32'h1004 -> COUNT unchanged.
REQ-036 rst pulse for 1 cycle while counting with MATCH=1 -> all registers at their reset values the next cycle, irq=0, and COUNT stays 0 for 10 cycles.
